nios_pio_out_pulse: RTL and testbench

//  Avalon-MM slave output PIO: host-writable bit register driving out_port (LEDs, PLL control strobes).

---
 rtl/nios_pio_out_pulse_if.sv | 14 +
 rtl/nios_pio_out_pulse.sv | 136 +++++++++++++
 tb/tb_nios_pio_out_pulse.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/nios_pio_out_pulse_if.sv
// nios_pio_out_pulse_if: Avalon-MM slave bus bundle for the output PIO.
interface nios_pio_out_pulse_if;
   localparam int unsigned AW = 3;
   localparam int unsigned DW = 32;

   logic [AW-1:0] address;
   logic          chipselect;
   logic          write_n;
   logic [DW-1:0] writedata;
   logic [DW-1:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_pio_out_pulse.sv
// nios_pio_out_pulse: Avalon-MM output PIO with atomic set/clear and per-bit one-shot pulses.
// Define NIOS_PIO_PULSE_EN to include the pulse engine (PLEN and PULSE registers).
module nios_pio_out_pulse #(
   parameter int unsigned WIDTH       = 8,
   parameter logic [31:0] RESET_VALUE = '0,
   parameter int unsigned PULSE_W     = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   nios_pio_out_pulse_if.slave bus,
   output logic [WIDTH-1:0]    out_port
);
   localparam int unsigned DW = 32;
   localparam logic [2:0] A_DATA  = 3'd0;
   localparam logic [2:0] A_PLEN  = 3'd2;
   localparam logic [2:0] A_PULSE = 3'd3;
   localparam logic [2:0] A_SET   = 3'd4;
   localparam logic [2:0] A_CLR   = 3'd5;
   localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

   logic             wr_c;
   logic [WIDTH-1:0] wd_bits;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] pulse_d;
   logic [WIDTH-1:0] out_q;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             unused_wd;

   assign wr_c      = bus.chipselect & ~bus.write_n;
   assign wd_bits   = bus.writedata[WIDTH-1:0];
   assign unused_wd = ^bus.writedata;

   // Data register: direct write plus atomic set/clear
   always_comb begin
      data_d = data_q;
      if (wr_c) begin
         case (bus.address)
            A_DATA:  data_d = wd_bits;
            A_SET:   data_d = data_q | wd_bits;
            A_CLR:   data_d = data_q & ~wd_bits;
            default: data_d = data_q;
         endcase
      end
   end

`ifdef NIOS_PIO_PULSE_EN
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [PULSE_W-1:0] len_q, len_d;
   logic [PULSE_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   mask_q, mask_d;
   logic               trig_c;

   assign trig_c = wr_c && (bus.address == A_PULSE) && (len_q != '0) && (wd_bits != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
      end
   end

   // Pulse engine: a trigger always wins over expiry and reloads the shared count
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      if (wr_c && (bus.address == A_PLEN)) begin
         len_d = bus.writedata[PULSE_W-1:0];
      end
      case (state_q)
         IDLE: begin
            if (trig_c) begin
               mask_d  = mask_q | wd_bits;
               cnt_d   = len_q;
               state_d = RUN;
            end
         end
         RUN: begin
            if (trig_c) begin
               mask_d = mask_q | wd_bits;
               cnt_d  = len_q;
            end else if (cnt_q == PULSE_W'(1)) begin
               mask_d  = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - PULSE_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pulse_d = mask_d;
`else
   assign pulse_d = '0;
`endif

   // Read mux sampled every clock, independent of chipselect
   always_comb begin
      rdata_d = '0;
      case (bus.address)
         A_DATA:  rdata_d = DW'(data_q);
`ifdef NIOS_PIO_PULSE_EN
         A_PLEN:  rdata_d = DW'(len_q);
         A_PULSE: rdata_d = DW'(mask_q);
`endif
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= RST_VAL;
         out_q   <= RST_VAL;
         rdata_q <= '0;
      end else begin
         data_q  <= data_d;
         out_q   <= data_d | pulse_d;
         rdata_q <= rdata_d;
      end
   end

   assign out_port     = out_q;
   assign bus.readdata = rdata_q;
endmodule

// File: tb/tb_nios_pio_out_pulse.sv
// tb_nios_pio_out_pulse: directed and random bus traffic checked against a
// time-based reference model of the output PIO and its pulse engine.
module tb_nios_pio_out_pulse;
   localparam int unsigned WIDTH = 8;
   localparam logic [7:0]  RST   = 8'hA5;
`ifdef NIOS_PIO_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [WIDTH-1:0] out_port;

   nios_pio_out_pulse_if bus ();

   nios_pio_out_pulse #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (32'h0000_00A5),
      .PULSE_W     (16)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int hi0   = 0;
   int hi1   = 0;

   // Reference model: pulses are tracked as a bit set plus the edge index at which they end
   logic [7:0]  m_data;
   logic [15:0] m_len;
   logic [7:0]  m_mask;
   longint      m_end;
   longint      m_n;
   logic [31:0] m_rd;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] busy(input longint after_edge);
      return (after_edge < m_end) ? m_mask : 8'h00;
   endfunction

   task automatic model_reset();
      m_data = RST;
      m_len  = '0;
      m_mask = '0;
      m_end  = 0;
      m_n    = 0;
      m_rd   = '0;
   endtask

   task automatic model_edge(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
      logic [7:0] pre_mask;
      pre_mask = busy(m_n);
      case (a)
         3'd0:    m_rd = {24'h0, m_data};
         3'd2:    m_rd = PULSE_EN ? {16'h0, m_len} : 32'h0;
         3'd3:    m_rd = PULSE_EN ? {24'h0, pre_mask} : 32'h0;
         default: m_rd = 32'h0;
      endcase
      m_n++;
      if (cs && !wn) begin
         case (a)
            3'd0: m_data = wd[7:0];
            3'd2: if (PULSE_EN) m_len = wd[15:0];
            3'd3: if (PULSE_EN && m_len != 0 && wd[7:0] != 0) begin
                     m_mask = pre_mask | wd[7:0];
                     m_end  = m_n + longint'(m_len);
                  end
            3'd4: m_data = m_data | wd[7:0];
            3'd5: m_data = m_data & ~wd[7:0];
            default: ;
         endcase
      end
   endtask

   task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
      bus.address    = a;
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.writedata  = wd;
      @(posedge clk);
      model_edge(a, cs, wn, wd);
      @(negedge clk);
      check_eq("out_port", 32'(out_port), 32'(m_data | busy(m_n)));
      check_eq("readdata", bus.readdata, m_rd);
      hi0 += int'(out_port[0]);
      hi1 += int'(out_port[1]);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] wd);
      step(a, 1'b1, 1'b0, wd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(3'd3, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check_eq("rst_out", 32'(out_port), 32'(RST));
      check_eq("rst_rd", bus.readdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [2:0]  a;
      logic        cs, wn;
      logic [31:0] wd;

      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      model_reset();
      #2;
      do_reset();

      // Reset value readback with one cycle latency
      step(3'd0, 1'b0, 1'b1, 32'h0);
      check_eq("t1_rd", bus.readdata, 32'h0000_00A5);

      // Direct write, atomic set, atomic clear
      wr(3'd0, 32'h0000_000F);
      check_eq("t2_data", 32'(out_port), 32'h0F);
      wr(3'd4, 32'hFFFF_FFF0);
      check_eq("t2_set", 32'(out_port), 32'hFF);
      wr(3'd5, 32'h0000_0003);
      check_eq("t2_clr", 32'(out_port), 32'hFC);

      if (PULSE_EN) begin
         wr(3'd0, 32'h0);
         wr(3'd2, 32'd5);
         hi0 = 0;
         wr(3'd3, 32'h01);
         idle(8);
         check_eq("t3_len", 32'(hi0), 32'd5);

         hi0 = 0;
         hi1 = 0;
         wr(3'd3, 32'h01);
         idle(2);
         wr(3'd3, 32'h02);
         idle(8);
         check_eq("t4_bit0", 32'(hi0), 32'd8);
         check_eq("t4_bit1", 32'(hi1), 32'd5);

         wr(3'd2, 32'd0);
         wr(3'd3, 32'hFF);
         check_eq("t5_nolen", 32'(out_port), 32'h00);
         wr(3'd2, 32'd4);
         hi0 = 0;
         wr(3'd3, 32'h01);
         wr(3'd2, 32'd3);
         idle(6);
         check_eq("t5_plen", 32'(hi0), 32'd4);

         wr(3'd2, 32'd5);
         wr(3'd3, 32'h01);
         idle(2);
         do_reset();
         step(3'd3, 1'b0, 1'b1, 32'h0);
         check_eq("t6_mask", bus.readdata, 32'h0);
         check_eq("t6_out", 32'(out_port), 32'(RST));
      end else begin
         wr(3'd2, 32'd5);
         wr(3'd3, 32'hFF);
         step(3'd2, 1'b0, 1'b1, 32'h0);
         check_eq("t6_plen0", bus.readdata, 32'h0);
         step(3'd3, 1'b0, 1'b1, 32'h0);
         check_eq("t6_pulse0", bus.readdata, 32'h0);
      end

      // Random traffic with occasional asynchronous resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         a  = 3'($urandom_range(0, 7));
         cs = ($urandom_range(0, 3) != 0);
         wn = ($urandom_range(0, 3) == 0);
         wd = $urandom();
         if (a == 3'd2) wd = 32'($urandom_range(0, 7));
         if (a == 3'd3 && $urandom_range(0, 3) == 0) wd = 32'h0;
         step(a, cs, wn, wd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
